// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path types: the fetch/decode slot record and the default queue depth.
package fetch_queue_pkg;

  localparam int FQ_DEPTH = 8;

  typedef struct packed {
    logic        en;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_data_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-wide fetch queue between fetch and decode: circular buffer taking up to two
// entries per cycle and presenting the two oldest to decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  fetch_data_t [1:0]        in_data,
  output logic                     full,
  output fetch_data_t [1:0]        out_data,
  output logic [1:0]               out_valid,
  input  logic [1:0]               deq_num,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_data_t   mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [1:0]    nenq, ndeq, deq_sat;
  logic          wr1_en, wr0_en;
  logic [PW-1:0] wr0_idx, head_p1;

  // Full leaves room for one more complete pair, so fetch never has to split one.
  assign full  = count_q > CW'(DEPTH - 2);
  assign count = count_q;

  // NOTE: every signal gets a default at the top of always_comb so no path can
  // leave it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    wr1_en  = reset & ~flush & ~full & in_data[1].en;
    wr0_en  = reset & ~flush & ~full & in_data[0].en;
    // A lone younger slot lands at tail, not tail+1.
    wr0_idx = tail_q + PW'(in_data[1].en);

    nenq    = full ? 2'd0 : ({1'b0, in_data[1].en} + {1'b0, in_data[0].en});
    deq_sat = (deq_num == 2'd3) ? 2'd2 : deq_num;
    // When count is below the request it is at most 1, so it fits in two bits.
    ndeq    = (count_q < CW'(deq_sat)) ? count_q[1:0] : deq_sat;

    head_d  = head_q + PW'(ndeq);
    tail_d  = tail_q + PW'(nenq);
    count_d = count_q + CW'(nenq) - CW'(ndeq);

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values; the reset here is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is never read
  // before it is written because out_valid is derived from count.
  always_ff @(posedge clk) begin
    if (wr1_en) mem_q[tail_q]  <= in_data[1];
    if (wr0_en) mem_q[wr0_idx] <= in_data[0];
  end

  always_comb begin
    head_p1        = head_q + PW'(1);
    out_valid      = {count_q != '0, count_q >= CW'(2)};
    out_data[1]    = mem_q[head_q];
    out_data[0]    = mem_q[head_p1];
    out_data[1].en = out_valid[1] & mem_q[head_q].en;
    out_data[0].en = out_valid[0] & mem_q[head_p1].en;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus predicts each cycle's visible state from
// a reference FIFO, a negedge monitor pops and compares it against the DUT.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 8;

  typedef struct {
    int          cnt;
    bit          full;
    bit [1:0]    vld;
    fetch_data_t d1;
    fetch_data_t d0;
  } obs_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flush;
  fetch_data_t [1:0]      in_data;
  logic                   full;
  fetch_data_t [1:0]      out_data;
  logic [1:0]             out_valid;
  logic [1:0]             deq_num;
  logic [$clog2(DEPTH):0] count;

  fetch_data_t ref_q[$];
  obs_t        exp_q[$];
  obs_t        mo;
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .full(full),
    .out_data(out_data), .out_valid(out_valid), .deq_num(deq_num), .count(count)
  );

  always #5 clk = ~clk;

  function automatic fetch_data_t mk(input bit en, input logic [31:0] pc);
    fetch_data_t d;
    d.en    = en;
    d.pc    = pc;
    d.instr = ~pc;
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // One cycle: record what the DUT must show now, drive inputs, advance the model.
  task automatic step(input bit e1, input logic [31:0] p1, input bit e0, input logic [31:0] p0,
                      input logic [1:0] dq, input bit fl, input bit rs);
    obs_t o;
    int   cnt, sat, nd;
    @(posedge clk);
    #1;
    cnt    = ref_q.size();
    o.cnt  = cnt;
    o.full = (DEPTH - cnt) < 2;
    o.vld  = {cnt >= 1, cnt >= 2};
    o.d1   = (cnt >= 1) ? ref_q[0] : '0;
    o.d0   = (cnt >= 2) ? ref_q[1] : '0;
    exp_q.push_back(o);
    cyc++;

    in_data[1] = mk(e1, p1);
    in_data[0] = mk(e0, p0);
    deq_num    = dq;
    flush      = fl;
    reset      = rs;

    if (!rs || fl) begin
      ref_q.delete();
    end else begin
      sat = (dq == 2'd3) ? 2 : int'(dq);
      nd  = (sat < cnt) ? sat : cnt;
      repeat (nd) void'(ref_q.pop_front());
      if (!o.full) begin
        if (e1) ref_q.push_back(mk(1'b1, p1));
        if (e0) ref_q.push_back(mk(1'b1, p0));
      end
    end
  endtask

  task automatic idle(input logic [1:0] dq);
    step(1'b0, 32'h0, 1'b0, 32'h0, dq, 1'b0, 1'b1);
  endtask

  task automatic pair(input logic [31:0] pc, input logic [1:0] dq);
    step(1'b1, pc, 1'b1, pc + 32'h4, dq, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mo = exp_q.pop_front();
      check("count", 64'(count), 64'(mo.cnt));
      check("full", 64'(full), 64'(mo.full));
      check("out_valid", 64'(out_valid), 64'(mo.vld));
      check("out1_en", 64'(out_data[1].en), 64'(mo.vld[1]));
      check("out0_en", 64'(out_data[0].en), 64'(mo.vld[0]));
      if (mo.vld[1]) check("out1_data", {out_data[1].pc, out_data[1].instr}, {mo.d1.pc, mo.d1.instr});
      if (mo.vld[0]) check("out0_data", {out_data[0].pc, out_data[0].instr}, {mo.d0.pc, mo.d0.instr});
    end
  end

  initial begin
    reset   = 1'b0;
    flush   = 1'b0;
    deq_num = 2'd0;
    in_data = '0;
    repeat (2) @(posedge clk);

    // Reset state, then fill: counts 2,4,6,8; the fifth pair arrives while full.
    pair(32'h100, 2'd0);
    pair(32'h108, 2'd0);
    pair(32'h110, 2'd0);
    pair(32'h118, 2'd0);
    pair(32'h120, 2'd0);
    repeat (5) idle(2'd2);

    // Threshold at count 7: full, so a pair is refused; deq_num=3 drains two.
    pair(32'h200, 2'd0);
    pair(32'h208, 2'd0);
    pair(32'h210, 2'd0);
    step(1'b0, 32'h0, 1'b1, 32'h218, 2'd0, 1'b0, 1'b1);
    pair(32'h220, 2'd0);
    repeat (5) idle(2'd3);

    // Order: A,B pair then C alone in the older slot.
    pair(32'hA00, 2'd0);
    step(1'b1, 32'hC00, 1'b0, 32'hDEAD, 2'd0, 1'b0, 1'b1);
    idle(2'd2);
    idle(2'd1);

    // Simultaneous: count 3, pair in with one out gives 4.
    pair(32'h300, 2'd0);
    step(1'b1, 32'h308, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    pair(32'h310, 2'd1);
    idle(2'd0);
    repeat (2) idle(2'd2);

    // Wrap: mixed enqueue widths and dequeue rates across many pointer laps.
    for (int i = 0; i < 20; i++)
      step((i % 4) != 3, 32'h1000 + 32'(i) * 8, (i % 3) != 0, 32'h1004 + 32'(i) * 8,
           2'(i % 3), 1'b0, 1'b1);
    repeat (5) idle(2'd2);

    // Flush at count 5 overrides a same-cycle pair and dequeue.
    pair(32'h500, 2'd0);
    pair(32'h508, 2'd0);
    step(1'b1, 32'h510, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    step(1'b1, 32'h518, 1'b1, 32'h51C, 2'd2, 1'b1, 1'b1);
    idle(2'd0);

    // Over-dequeue from count 1.
    step(1'b0, 32'h0, 1'b1, 32'h600, 2'd0, 1'b0, 1'b1);
    idle(2'd2);
    idle(2'd0);

    // Reset while full, with a pair on the inputs.
    pair(32'h700, 2'd0);
    pair(32'h708, 2'd0);
    pair(32'h710, 2'd0);
    pair(32'h718, 2'd0);
    step(1'b1, 32'h720, 1'b1, 32'h724, 2'd1, 1'b0, 1'b0);
    idle(2'd0);
    pair(32'h800, 2'd0);
    idle(2'd1);
    idle(2'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
